// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M encodings and the multiply/divide sequencer state type.
package rv32m_pkg;

  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_ITER = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } md_state_e;

  // Divide-group ops with funct3[0]=0 (DIV/REM) are signed.
  function automatic logic f_div_is_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  function automatic logic f_div_is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_core.sv
// Restoring-divider datapath: one quotient bit per step, unsigned magnitudes only.
module md_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;

  logic [XLEN:0]   w_rem_sh;
  logic            w_fits;
  logic [XLEN-1:0] w_sub;

  // Dividend bits shift out of r_quo into the partial remainder as quotient bits shift in.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_div});
  assign w_sub    = w_rem_sh[XLEN-1:0] - r_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_fits ? w_sub : w_rem_sh[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_fits};
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: registered multiplier plus iterative divider, stalls EX while busy.
module muldiv_sequencer
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'(XLEN - 1);

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [5:0]        r_cnt;
  logic [2:0]        r_funct3;
  logic              r_q_neg;
  logic              r_r_neg;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_result;

  logic                     w_accept;
  logic                     w_div_signed;
  logic                     w_a_neg;
  logic                     w_b_neg;
  logic                     w_b_zero;
  logic                     w_ovf;
  logic                     w_special;
  logic                     w_div_load;
  logic                     w_div_step;
  logic                     w_load_result;
  logic [XLEN-1:0]          w_a_mag;
  logic [XLEN-1:0]          w_b_mag;
  logic [XLEN-1:0]          w_special_res;
  logic [XLEN-1:0]          w_mul_res;
  logic [XLEN-1:0]          w_div_res;
  logic [XLEN-1:0]          w_result_nxt;
  logic [XLEN-1:0]          w_quo;
  logic [XLEN-1:0]          w_rem;
  logic signed [2*XLEN-1:0] w_a_ext;
  logic signed [2*XLEN-1:0] w_b_ext;
  logic signed [2*XLEN-1:0] w_prod;

  assign w_accept = (r_state == ST_IDLE) & valid_i & ~flush_i;

  // Sign-extending to 2*XLEN and keeping the low 2*XLEN product bits equals the 33x33 product.
  assign w_a_ext = {{XLEN{(funct3_i[1:0] != 2'b11) & a_i[XLEN-1]}}, a_i};
  assign w_b_ext = {{XLEN{~funct3_i[1] & b_i[XLEN-1]}}, b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_div_signed = f_div_is_signed(funct3_i);
  assign w_a_neg      = w_div_signed & a_i[XLEN-1];
  assign w_b_neg      = w_div_signed & b_i[XLEN-1];
  assign w_a_mag      = w_a_neg ? -a_i : a_i;
  assign w_b_mag      = w_b_neg ? -b_i : b_i;

  assign w_b_zero  = (b_i == '0);
  assign w_ovf     = w_div_signed & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
  assign w_special = w_b_zero | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_b_zero)
      w_special_res = f_div_is_rem(funct3_i) ? a_i : '1;
    else if (w_ovf)
      w_special_res = f_div_is_rem(funct3_i) ? '0 : a_i;
  end

  md_div_core #(
    .XLEN(XLEN)
  ) u_div (
    .clk         (clk),
    .rst         (reset),
    .i_load      (w_div_load),
    .i_step      (w_div_step),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_mul_res = (r_funct3 == FUNCT3_MUL) ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN];
  assign w_div_res = f_div_is_rem(r_funct3) ? (r_r_neg ? -w_rem : w_rem)
                                            : (r_q_neg ? -w_quo : w_quo);

  always_comb begin
    w_state_nxt    = r_state;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    w_div_load     = 1'b0;
    w_div_step     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall_o = w_accept;
        if (w_accept) begin
          if (!funct3_i[2])
            w_state_nxt = ST_MUL_WAIT;
          else if (w_special)
            w_state_nxt = ST_DONE;
          else begin
            w_state_nxt = ST_DIV_ITER;
            w_div_load  = 1'b1;
          end
        end
      end
      ST_MUL_WAIT: begin
        stall_o = 1'b1;
        if (r_cnt == MUL_LAST)
          w_state_nxt = ST_DONE;
      end
      ST_DIV_ITER: begin
        stall_o    = 1'b1;
        w_div_step = 1'b1;
        if (r_cnt == DIV_LAST)
          w_state_nxt = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        stall_o     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        result_valid_o = ~flush_i;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush_i)
      w_state_nxt = ST_IDLE;
    // Async reset must force every output low immediately, including comb ones.
    if (reset) begin
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
    end
  end

  assign w_load_result = (w_state_nxt == ST_DONE) & (r_state != ST_DONE);

  always_comb begin
    w_result_nxt = w_div_res;
    case (r_state)
      ST_IDLE:     w_result_nxt = w_special_res;
      ST_MUL_WAIT: w_result_nxt = w_mul_res;
      default:     w_result_nxt = w_div_res;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_prod   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if ((r_state == ST_MUL_WAIT) || (r_state == ST_DIV_ITER))
        r_cnt <= r_cnt + 6'd1;
      if (w_accept) begin
        r_funct3 <= funct3_i;
        r_q_neg  <= w_a_neg ^ w_b_neg;
        r_r_neg  <= w_a_neg;
        if (!funct3_i[2])
          r_prod <= w_prod;
      end
      if (w_load_result)
        r_result <= w_result_nxt;
    end
  end

  assign result_o = r_result;
  assign busy_o   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: results, latency, stall shape, flush and reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  muldiv_sequencer #(
    .XLEN    (32),
    .MUL_LAT (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .funct3_i       (funct3_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid_o === 1'b1) n_pulses++;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts at a cycle start (just after posedge); returns at the cycle after the result.
  task automatic check_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
    int          got_cyc;
    int          stall_bad;
    logic [31:0] res;
    got_cyc   = -1;
    stall_bad = 0;
    res       = 'x;
    valid_i   = 1'b1;
    funct3_i  = f3;
    a_i       = a;
    b_i       = b;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (stall_o !== (c < lat)) stall_bad++;
      if (result_valid_o === 1'b1) begin
        got_cyc = c;
        res     = result_o;
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      if (got_cyc >= 0) break;
    end
    chk({nm, " latency"}, got_cyc, lat);
    chk({nm, " result"}, res, exp);
    chk({nm, " stall shape"}, stall_bad, 0);
    chk({nm, " single pulse"}, {31'b0, result_valid_o}, 0);
    chk({nm, " back to idle"}, {31'b0, busy_o}, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p0;
    int stall_bad;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB,  3, "MUL 7*-3"};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  3, "MULHU max"};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF,  3, "MULHSU -1*2"};
    vecs[3]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,  3, "MULH min*min"};
    vecs[4]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34, "DIVU 100/7"};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "REM -7/2"};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "DIV -7/2"};
    vecs[7]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, "DIV ovf"};
    vecs[8]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,  1, "REM ovf"};
    vecs[9]  = '{3'b111, 32'd7,         32'd0,         32'd7,          1, "REMU by 0"};
    vecs[10] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF,  1, "DIV by 0"};
    vecs[11] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF,  1, "DIVU by 0"};
    vecs[12] = '{3'b111, 32'd100,       32'd7,         32'd2,         34, "REMU 100%7"};
    vecs[13] = '{3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, "DIV 100/-7"};
    vecs[14] = '{3'b110, 32'd100,       32'hFFFF_FFF9, 32'd2,         34, "REM 100%-7"};
    vecs[15] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "REMU big"};

    // Reset with a pending op on the inputs: everything must stay low.
    valid_i  = 1'b1;
    funct3_i = 3'b000;
    a_i      = 32'd7;
    b_i      = 32'd3;
    @(posedge clk);
    #2;
    chk("reset stall", {31'b0, stall_o}, 0);
    chk("reset result_valid", {31'b0, result_valid_o}, 0);
    chk("reset result", result_o, 0);
    chk("reset busy", {31'b0, busy_o}, 0);
    valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors run back to back, each accepted in the cycle after the previous DONE.
    for (int i = 0; i < 16; i++)
      check_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].nm);

    // Flush at cycle 10 of a DIVU, then a MUL in cycle 11.
    p0        = n_pulses;
    stall_bad = 0;
    valid_i   = 1'b1;
    funct3_i  = 3'b101;
    a_i       = 32'd100;
    b_i       = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (stall_o !== 1'b1) stall_bad++;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush cycle result_valid", {31'b0, result_valid_o}, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush idle busy", {31'b0, busy_o}, 0);
    chk("flush idle stall", {31'b0, stall_o}, 0);
    chk("flush div stall shape", stall_bad, 0);
    chk("flush no pulse", n_pulses - p0, 0);
    check_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3, "MUL after flush");

    // Flush beats a simultaneous accept.
    valid_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = 3'b101;
    a_i      = 32'd9;
    b_i      = 32'd3;
    #1;
    chk("flush vs accept stall", {31'b0, stall_o}, 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush vs accept busy", {31'b0, busy_o}, 0);
    chk("flush vs accept result held", result_o, 32'hFFFF_FFEB);

    // Reset asserted mid-DIV_ITER, then two ops back to back.
    p0       = n_pulses;
    valid_i  = 1'b1;
    funct3_i = 3'b101;
    a_i      = 32'd1000;
    b_i      = 32'd3;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    chk("mid-div busy before reset", {31'b0, busy_o}, 1);
    reset = 1'b1;
    #1;
    chk("async reset stall", {31'b0, stall_o}, 0);
    chk("async reset result_valid", {31'b0, result_valid_o}, 0);
    chk("async reset result", result_o, 0);
    chk("async reset busy", {31'b0, busy_o}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("aborted op no pulse", n_pulses - p0, 0);
    p0 = n_pulses;
    check_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "DIVU after reset");
    check_op(3'b000, 32'd6, 32'd7, 32'd42, 3, "MUL after reset");
    chk("post-reset pulse count", n_pulses - p0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
